// File: rtl/q_loop_sequencer_if.sv
// rtl/q_loop_sequencer_if.sv - control/measurement handshake bundle for q_loop_sequencer
interface q_loop_sequencer_if #(
  parameter int BUS_WIDTH = 10,
  parameter int MAX_ITER  = 16
);
  logic                          run;
  logic                          q_ready;
  logic [BUS_WIDTH-1:0]          q_measured;
  logic [BUS_WIDTH-1:0]          q_desired;
  logic                          went_unstable;
  logic                          start_o;
  logic                          enable_o;
  logic                          busy;
  logic                          converged;
  logic                          fault;
  logic [1:0]                    fault_code;
  logic [$clog2(MAX_ITER+1)-1:0] iter_count;

  modport master (
    input  run, q_ready, q_measured, q_desired, went_unstable,
    output start_o, enable_o, busy, converged, fault, fault_code, iter_count
  );

  modport slave (
    output run, q_ready, q_measured, q_desired, went_unstable,
    input  start_o, enable_o, busy, converged, fault, fault_code, iter_count
  );
endinterface

// File: rtl/q_loop_sequencer.sv
// rtl/q_loop_sequencer.sv - Q-control loop sequencer: settle, start, measure, evaluate, supervise
// Optional instability abort (fault_code 11) is built when Q_SEQ_UNSTABLE_ABORT_EN is defined.
module q_loop_sequencer #(
  parameter int BUS_WIDTH      = 10,
  parameter int TOL            = 1,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CONV_COUNT     = 2,
  parameter int MAX_ITER       = 16
) (
  input logic                clk,
  input logic                rst,
  q_loop_sequencer_if.master bus
);
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int CW = $clog2(CONV_COUNT + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SW-1:0]        SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TW-1:0]        TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]        ITER_MAX    = IW'(MAX_ITER);
  localparam logic [CW-1:0]        CONV_MAX    = CW'(CONV_COUNT);
  localparam logic [BUS_WIDTH:0]   TOL_W       = (BUS_WIDTH + 1)'(TOL);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_MAX_ITER = 2'b10;
  localparam logic [1:0] FC_UNSTABLE = 2'b11;

  typedef enum logic [2:0] {IDLE, SETTLE, START, MEASURE, EVAL, DONE, FAULT} state_t;

  state_t               state, state_n;
  logic [SW-1:0]        settle_cnt, settle_n;
  logic [TW-1:0]        tmo_cnt, tmo_n;
  logic [IW-1:0]        iter_cnt, iter_n, iter_inc;
  logic [CW-1:0]        conv_cnt, conv_n, conv_inc;
  logic [1:0]           code, code_n;
  logic [BUS_WIDTH-1:0] target, target_n, meas, meas_n;
  logic [BUS_WIDTH:0]   meas_w, target_w, diff;
  logic                 in_band, busy_state;
  logic                 start_r, enable_r, busy_r, conv_r, fault_r;

  // Widen by one bit so the absolute difference never wraps.
  assign meas_w   = {1'b0, meas};
  assign target_w = {1'b0, target};
  assign diff     = (meas_w >= target_w) ? meas_w - target_w : target_w - meas_w;
  assign in_band  = (diff <= TOL_W);

  assign iter_inc = (iter_cnt == ITER_MAX) ? iter_cnt : iter_cnt + 1'b1;
  assign conv_inc = !in_band ? '0 : (conv_cnt == CONV_MAX) ? conv_cnt : conv_cnt + 1'b1;
  assign busy_state = (state == SETTLE) || (state == START) ||
                      (state == MEASURE) || (state == EVAL);

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    tmo_n    = tmo_cnt;
    iter_n   = iter_cnt;
    conv_n   = conv_cnt;
    code_n   = code;
    target_n = target;
    meas_n   = meas;
    case (state)
      IDLE: if (bus.run) begin
        target_n = bus.q_desired;
        iter_n   = '0;
        conv_n   = '0;
        code_n   = FC_NONE;
        settle_n = '0;
        state_n  = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_n = START;
        else settle_n = settle_cnt + 1'b1;
      end
      START: begin
        tmo_n   = '0;
        state_n = MEASURE;
      end
      MEASURE: begin
        if (bus.q_ready) begin
          meas_n  = bus.q_measured;
          state_n = EVAL;
        end else if (tmo_cnt == TMO_LAST) begin
          code_n  = FC_TIMEOUT;
          state_n = FAULT;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      EVAL: begin
        iter_n = iter_inc;
        conv_n = conv_inc;
        if (conv_inc == CONV_MAX) begin
          state_n = DONE;
        end else if (iter_inc == ITER_MAX) begin
          code_n  = FC_MAX_ITER;
          state_n = FAULT;
        end else begin
          settle_n = '0;
          state_n  = SETTLE;
        end
      end
      DONE, FAULT: if (!bus.run) state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef Q_SEQ_UNSTABLE_ABORT_EN
    if (bus.went_unstable && ((state == MEASURE) || (state == EVAL))) begin
      code_n  = FC_UNSTABLE;
      state_n = FAULT;
    end
`endif
    // An abort beats everything else, including a just-raised fault.
    if (!bus.run && busy_state) begin
      code_n  = code;
      state_n = IDLE;
    end
  end

`ifndef Q_SEQ_UNSTABLE_ABORT_EN
  logic unused_went_unstable;
  assign unused_went_unstable = bus.went_unstable;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      iter_cnt   <= '0;
      conv_cnt   <= '0;
      code       <= FC_NONE;
      target     <= '0;
      meas       <= '0;
      start_r    <= 1'b0;
      enable_r   <= 1'b0;
      busy_r     <= 1'b0;
      conv_r     <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      tmo_cnt    <= tmo_n;
      iter_cnt   <= iter_n;
      conv_cnt   <= conv_n;
      code       <= code_n;
      target     <= target_n;
      meas       <= meas_n;
      start_r    <= (state_n == START);
      enable_r   <= (state_n == MEASURE);
      busy_r     <= (state_n == SETTLE) || (state_n == START) ||
                    (state_n == MEASURE) || (state_n == EVAL);
      conv_r     <= (state_n == DONE);
      fault_r    <= (state_n == FAULT);
    end
  end

  assign bus.start_o    = start_r;
  assign bus.enable_o   = enable_r;
  assign bus.busy       = busy_r;
  assign bus.converged  = conv_r;
  assign bus.fault      = fault_r;
  assign bus.fault_code = code;
  assign bus.iter_count = iter_cnt;
endmodule

// File: tb/tb_q_loop_sequencer.sv
// tb/tb_q_loop_sequencer.sv - scoreboard bench for q_loop_sequencer with a modelled Q measurement block
module tb_q_loop_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q_loop_sequencer_if #(.BUS_WIDTH(10), .MAX_ITER(16)) bus ();
  q_loop_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [9:0] val; int delay; } resp_t;
  typedef struct { logic conv; logic flt; logic [1:0] code; logic [4:0] iter; int starts; } exp_t;

  resp_t resp_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    start_cnt = 0;
  int    n;
  logic  prev_run = 1'b0;
  logic  prev_term = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return 32'({bus.start_o, bus.enable_o, bus.busy, bus.converged, bus.fault,
                bus.fault_code, bus.iter_count});
  endfunction

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic add_resp(input logic [9:0] v, input int d);
    resp_t r;
    r.val = v;
    r.delay = d;
    resp_q.push_back(r);
  endtask

  task automatic push_exp(input logic c, input logic f, input logic [1:0] code, input logic [4:0] it, input int st);
    exp_t e;
    e.conv = c; e.flt = f; e.code = code; e.iter = it; e.starts = st;
    exp_q.push_back(e);
  endtask

  task automatic begin_run(input logic [9:0] d);
    bus.q_desired = d;
    bus.run = 1'b1;
  endtask

  task automatic end_run();
    bus.run = 1'b0;
    cyc(3);
  endtask

  task automatic wait_term(input string name, input int budget);
    int k = 0;
    while (!(bus.converged || bus.fault) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(bus.converged || bus.fault)) begin
      checks++;
      errors++;
      $display("FAIL %s: no DONE/FAULT within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_enable(input string name, input int budget);
    int k = 0;
    while (!bus.enable_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!bus.enable_o) begin
      checks++;
      errors++;
      $display("FAIL %s: enable_o not seen within %0d cycles", name, budget);
    end
  endtask

  // Q measurement model: answers a start pulse after a per-entry delay.
  initial begin
    resp_t r;
    bus.q_ready = 1'b0;
    bus.q_measured = '0;
    forever begin
      @(negedge clk);
      if (bus.start_o && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        repeat (r.delay) @(negedge clk);
        bus.q_measured = r.val;
        bus.q_ready = 1'b1;
        @(negedge clk);
        bus.q_ready = 1'b0;
      end
    end
  end

  // Monitor: counts start pulses per run and scores each DONE/FAULT entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.run && !prev_run) start_cnt = 0;
      prev_run = bus.run;
      if (bus.start_o) start_cnt++;
      if ((bus.converged || bus.fault) && !prev_term) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_terminal: conv=%0b fault=%0b code=%0d iter=%0d, expected none",
                   bus.converged, bus.fault, bus.fault_code, bus.iter_count);
        end else begin
          e = exp_q.pop_front();
          chk("term_converged", bus.converged, e.conv);
          chk("term_fault", bus.fault, e.flt);
          chk("term_fault_code", bus.fault_code, e.code);
          chk("term_iter_count", bus.iter_count, e.iter);
          chk("term_start_pulses", start_cnt, e.starts);
        end
      end
      prev_term = bus.converged || bus.fault;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.run = 1'b0;
    bus.q_desired = '0;
    bus.went_unstable = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("reset_outputs", outs(), 0);

    // Latency to first start, pulse width, then reset while measuring.
    begin_run(10'd500);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.start_o && n < 20);
    chk("start_latency", n, 5);
    cyc(1);
    chk("start_width", bus.start_o, 0);
    chk("measure_enable", bus.enable_o, 1);
    cyc(5);
    rst = 1'b0;
    bus.run = 1'b0;
    cyc(1);
    chk("reset_mid_measure", outs(), 0);
    rst = 1'b1;
    cyc(3);

    // Converge after 480, 499, 501 against 500.
    add_resp(10'd480, 3); add_resp(10'd499, 3); add_resp(10'd501, 3);
    push_exp(1'b1, 1'b0, 2'b00, 5'd3, 3);
    begin_run(10'd500);
    wait_term("converge", 300);
    cyc(10);
    chk("done_hold", bus.converged, 1);
    chk("done_not_busy", bus.busy, 0);
    bus.run = 1'b0;
    cyc(1);
    chk("done_exit_outputs", outs(), 3);
    cyc(2);

    // No answer at all: timeout after exactly 256 MEASURE cycles.
    push_exp(1'b0, 1'b1, 2'b01, 5'd0, 1);
    begin_run(10'd500);
    wait_enable("timeout_enable", 20);
    n = 0;
    while (!bus.fault && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 256);
    cyc(2);
    bus.run = 1'b0;
    cyc(1);
    chk("idle_holds_code", bus.fault_code, 1);
    chk("idle_fault_low", bus.fault, 0);
    rst = 1'b0;
    cyc(1);
    chk("reset_clears_code", bus.fault_code, 0);
    rst = 1'b1;
    cyc(2);

    // q_ready on the last timeout cycle wins.
    add_resp(10'd500, 256); add_resp(10'd500, 3);
    push_exp(1'b1, 1'b0, 2'b00, 5'd2, 2);
    begin_run(10'd500);
    wait_term("timeout_boundary", 700);
    cyc(2);
    end_run();

    // Never in band: max-iteration fault after 16 starts.
    for (int i = 0; i < 16; i++) add_resp(10'd600, 3);
    push_exp(1'b0, 1'b1, 2'b10, 5'd16, 16);
    begin_run(10'd500);
    wait_term("max_iter", 1000);
    cyc(20);
    chk("max_iter_no_extra_start", start_cnt, 16);
    end_run();

    // Convergence on the 16th measurement beats max_iter.
    for (int i = 0; i < 14; i++) add_resp(10'd600, 3);
    add_resp(10'd500, 3); add_resp(10'd500, 3);
    push_exp(1'b1, 1'b0, 2'b00, 5'd16, 16);
    begin_run(10'd500);
    wait_term("iter16_converge", 1000);
    cyc(2);
    end_run();

    // Abort during SETTLE.
    add_resp(10'd600, 3);
    begin_run(10'd500);
    n = 0;
    while (bus.iter_count != 5'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drop_in_settle_busy", bus.busy, 1);
    bus.run = 1'b0;
    cyc(1);
    chk("drop_idle_outputs", outs(), 1);
    cyc(20);
    chk("drop_no_more_start", start_cnt, 1);

    // Instability pulse while measuring.
    add_resp(10'd500, 3); add_resp(10'd500, 3);
`ifdef Q_SEQ_UNSTABLE_ABORT_EN
    push_exp(1'b0, 1'b1, 2'b11, 5'd0, 1);
`else
    push_exp(1'b1, 1'b0, 2'b00, 5'd2, 2);
`endif
    begin_run(10'd500);
    wait_enable("unstable_enable", 20);
    bus.went_unstable = 1'b1;
    cyc(1);
    bus.went_unstable = 1'b0;
    wait_term("unstable", 300);
    cyc(10);
    end_run();
    resp_q.delete();
    cyc(5);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/q_loop_sequencer.md
Name: q_loop_sequencer

Overview:
- Sequences the Q-control loop: issues measurement start pulses, gates the bisection/sampling enable, and inserts settle time between current-reference updates.
- Supervises the loop: measurement timeout, convergence detection, iteration limit.
- Sits beside the Q-control top; drives its start/enable inputs and observes its measurement handshake.

Parameters:
- BUS_WIDTH, 10, width of the q_desired and q_measured buses
- TOL, 1, convergence band in Q counts: converged when |q_measured - q_desired| <= TOL
- SETTLE_CYCLES, 4, idle cycles after each i_ref update before the next start; 0 is legal
- TIMEOUT_CYCLES, 256, maximum cycles in MEASURE waiting for q_ready
- CONV_COUNT, 2, consecutive in-band measurements required to declare convergence (>=1)
- MAX_ITER, 16, measurement limit per run (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- run  in  1  level; 1 = run the loop, 0 = abort/return to IDLE
- q_ready  in  1  measurement-complete pulse from the Q measurement block
- q_measured  in  BUS_WIDTH  measured Q; valid when q_ready=1
- q_desired  in  BUS_WIDTH  target Q; sampled on leaving IDLE
- went_unstable  in  1  instability flag from the controller (see Optional Feature)
- start_o  out  1  one-cycle measurement start pulse
- enable_o  out  1  enable for the bisection and i_ref sampling blocks
- busy  out  1  high in SETTLE/START/MEASURE/EVAL
- converged  out  1  high in DONE
- fault  out  1  high in FAULT
- fault_code  out  2  00 none, 01 timeout, 10 max_iter, 11 unstable
- iter_count  out  $clog2(MAX_ITER+1)  measurements completed in the current run

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; all outputs 0; internal counters and latched target cleared.
- Registered outputs; all are decoded from the state and counters.

States and transitions:
- IDLE: outputs 0 except fault_code/iter_count, which hold their last values until the next run. If run=1: latch q_desired; clear iter_count, conv_cnt, fault_code; go to SETTLE.
- SETTLE: hold SETTLE_CYCLES cycles, then go to START. With SETTLE_CYCLES=0, spend one cycle in SETTLE.
- START: start_o=1 for exactly this one cycle; clear the timeout counter; go to MEASURE.
- MEASURE: enable_o=1.
  - On q_ready: latch q_measured; go to EVAL.
  - If TIMEOUT_CYCLES cycles elapse with no q_ready: fault_code=01; go to FAULT.
  - If q_ready arrives on the same cycle the timeout expires, q_ready wins.
- EVAL (1 cycle, enable_o=0):
  - diff = |q_meas - q_target|, computed at BUS_WIDTH+1 bits with no wrap.
  - iter_count += 1.
  - conv_cnt = in-band ? conv_cnt+1 : 0.
  - If the new conv_cnt == CONV_COUNT: go to DONE.
  - Else if the new iter_count == MAX_ITER: fault_code=10; go to FAULT. Convergence has priority on the same cycle.
  - Else go to SETTLE.
- DONE: converged=1, busy=0; hold until run=0, then go to IDLE.
- FAULT: fault=1, busy=0; hold until run=0, then go to IDLE.

Boundary rules:
- run=0 in any busy state: IDLE on the next cycle; no further start_o.
- q_ready outside MEASURE: ignored.
- q_desired changes mid-run: ignored until the next run.
- iter_count saturates at MAX_ITER.
- Reset mid-operation: immediate IDLE on that edge; start_o never extends past one cycle.
- Latency, run rising to first start_o: 1 (IDLE) + max(SETTLE_CYCLES,1) cycles.

Optional Feature:
- Macro: Q_SEQ_UNSTABLE_ABORT_EN.
- Defined: went_unstable=1 while in MEASURE or EVAL sets fault_code=11 and moves to FAULT on the next cycle. This has priority over q_ready, timeout, convergence and max_iter.
- Not defined: went_unstable is present but ignored; fault_code 11 is never produced.

Test Plan:
- Reset then run=1: start_o rises exactly 5 cycles after run is sampled (defaults) and lasts 1 cycle. Drive rst=0 mid-MEASURE: all outputs 0 on the next cycle.
- q_desired=500; respond to each start with q_ready 3 cycles later, q_measured=480, 499, 501 -> iter_count=3, converged=1, fault=0. Holds until run=0, then IDLE.
- Never assert q_ready: fault=1, fault_code=01 exactly 256 cycles after entering MEASURE. Assert q_ready on that same cycle instead -> no fault; EVAL follows.
- Always answer q_measured=600 with q_desired=500 -> fault_code=10 after iter_count=16; exactly 16 start pulses issued.
- Answer in-band at iteration 16 (after a prior in-band 15th) -> converged=1, not fault. Drop run mid-SETTLE -> no further start_o; IDLE next cycle.
- Q_SEQ_UNSTABLE_ABORT_EN defined: pulse went_unstable in MEASURE -> fault_code=11. Without the macro: same stimulus -> no fault, loop continues.
